// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared FSM state encoding and mode constants for the button capture path.
package btn_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      LOAD     = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;
   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_FOLLOW = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous board inputs, async active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[0], d};
   always_ff @(posedge clk or posedge reset)
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
   assign q = sync_q[1];
endmodule

// File: rtl/btn_capture_ctrl.sv
// btn_capture_ctrl: synchronise and debounce a button, then issue one load strobe per press
// followed by a lockout window; d_out toggles or follows the debounced level.
module btn_capture_ctrl
   import btn_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LOCKOUT_CYCLES  = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       mode,
   output logic       load,
   output logic       d_out,
   output logic       busy,
   output logic [7:0] press_cnt
);
   localparam int MAX_CYC = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'((LOCKOUT_CYCLES == 0) ? 0 : LOCKOUT_CYCLES - 1);

   logic             btn_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_level_q, db_level_d;
   logic             d_out_q, d_out_d;
   logic             load_q, load_d;
   logic             busy_q, busy_d;
   logic [7:0]       press_cnt_q, press_cnt_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_raw),
      .q     (btn_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      db_level_d  = db_level_q;
      d_out_d     = d_out_q;
      press_cnt_d = press_cnt_q;
      case (state_q)
         IDLE: if (btn_s != db_level_q) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
         end
         DEBOUNCE: if (btn_s == db_level_q) state_d = IDLE;
         else if (cnt_q == DEB_LAST) begin
            db_level_d = btn_s;
            // toggle mode only acts on presses; follow mode acts on every change
            if (btn_s || mode == MODE_FOLLOW) begin
               state_d     = LOAD;
               d_out_d     = (mode == MODE_TOGGLE) ? ~d_out_q : btn_s;
               press_cnt_d = press_cnt_q + 8'd1;
            end else state_d = IDLE;
         end else cnt_d = cnt_q + 1'b1;
         LOAD: begin
            state_d = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
            cnt_d   = '0;
         end
         LOCKOUT: if (cnt_q == LOCK_LAST) state_d = IDLE;
         else cnt_d = cnt_q + 1'b1;
      endcase
      load_d = (state_d == LOAD);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         db_level_q  <= 1'b0;
         d_out_q     <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         press_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         db_level_q  <= db_level_d;
         d_out_q     <= d_out_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         press_cnt_q <= press_cnt_d;
      end

   assign load      = load_q;
   assign d_out     = d_out_q;
   assign busy      = busy_q;
   assign press_cnt = press_cnt_q;
endmodule

// File: tb/tb_btn_capture_ctrl.sv
// tb_btn_capture_ctrl: directed and random stimulus against a timestamp-based reference model
// of the debounce / load / lockout behaviour.
module tb_btn_capture_ctrl;
   localparam int D = 4;
   localparam int L = 8;

   logic       clk = 0, reset = 0, btn_raw = 0, mode = 0;
   logic       load, d_out, busy;
   logic [7:0] press_cnt;

   int n_chk = 0, n_pass = 0, n_load = 0;

   // model: edge index, sync pipe, debounce start edge, first edge after lockout
   int t = 0, deb_since = -1, lock_end = 0, load_edge = -1, m_press = 0;
   bit m_s1 = 0, m_s2 = 0, m_db = 0, m_dout = 0, exp_load = 0, exp_busy = 0;

   always #5 clk = ~clk;

   btn_capture_ctrl #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .mode      (mode),
      .load      (load),
      .d_out     (d_out),
      .busy      (busy),
      .press_cnt (press_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dout = 0; m_press = 0;
      deb_since = -1; lock_end = 0; load_edge = -1; exp_load = 0; exp_busy = 0;
   endtask

   task automatic model_edge(input bit raw, input bit md);
      bit bs;
      bs = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      if (t >= lock_end) begin
         if (deb_since < 0) begin
            if (bs != m_db) deb_since = t;
         end else if (bs == m_db) deb_since = -1;
         else if (t - deb_since == D) begin
            m_db = bs;
            deb_since = -1;
            if (md || bs) begin
               m_dout = md ? bs : !m_dout;
               m_press = (m_press + 1) % 256;
               load_edge = t;
               lock_end = t + L + 2;
            end
         end
      end
      exp_load = (load_edge == t);
      exp_busy = (deb_since >= 0) || (t < lock_end - 1);
      t++;
   endtask

   task automatic step(input bit r, input bit md);
      btn_raw = r;
      mode = md;
      @(posedge clk);
      model_edge(r, md);
      #1;
      if (load === 1'b1) n_load++;
      chk("load", load, exp_load);
      chk("d_out", d_out, m_dout);
      chk("busy", busy, exp_busy);
      chk("press_cnt", press_cnt, m_press);
   endtask

   task automatic hold(input bit r, input bit md, input int n);
      for (int i = 0; i < n; i++) step(r, md);
   endtask

   task automatic do_reset();
      #2 reset = 1;
      #1;
      model_reset();
      chk("rst_load", load, 0);
      chk("rst_d_out", d_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_press_cnt", press_cnt, 0);
      #1 reset = 0;
      n_load = 0;
   endtask

   initial begin
      int k, bcnt;
      bit seen;
      // 1: reset with button held, first load on the 7th edge
      btn_raw = 1;
      do_reset();
      seen = 0;
      k = 0;
      while (!seen && k < 20) begin
         step(1, 0);
         k++;
         if (load === 1'b1) seen = 1;
      end
      chk("t1_latency", k, 7);
      chk("t1_d_out", d_out, 1);
      chk("t1_press", press_cnt, 1);
      // 2: toggle mode, press / release / press
      btn_raw = 0;
      do_reset();
      hold(1, 0, 20); hold(0, 0, 20); hold(1, 0, 20);
      chk("t2_loads", n_load, 2);
      chk("t2_d_out", d_out, 0);
      chk("t2_press", press_cnt, 2);
      // 3: bounce shorter than the debounce window
      do_reset();
      bcnt = 0;
      for (int i = 0; i < 3; i++) begin step(1, 0); bcnt += int'(busy === 1'b1); end
      for (int i = 0; i < 15; i++) begin step(0, 0); bcnt += int'(busy === 1'b1); end
      chk("t3_loads", n_load, 0);
      chk("t3_busy_max", int'(bcnt <= 4), 1);
      chk("t3_busy_end", busy, 0);
      // 4: release and re-press inside the lockout window
      do_reset();
      k = 0;
      while (n_load == 0 && k < 20) begin step(1, 0); k++; end
      hold(1, 0, 2); hold(0, 0, 2); hold(1, 0, 30);
      chk("t4_loads", n_load, 1);
      chk("t4_press", press_cnt, 1);
      // 5: follow mode
      do_reset();
      hold(1, 1, 20); hold(0, 1, 20);
      chk("t5_loads", n_load, 2);
      chk("t5_d_out", d_out, 0);
      chk("t5_press", press_cnt, 2);
      // 6: press counter wrap, then reset in the middle of a debounce
      do_reset();
      for (int i = 0; i < 256; i++) begin hold(1, 0, 20); hold(0, 0, 20); end
      chk("t6_wrap", press_cnt, 0);
      chk("t6_loads", n_load, 256);
      hold(1, 0, 4);
      chk("t6_busy_pre", busy, 1);
      do_reset();
      hold(0, 0, 20);
      chk("t6_no_load", n_load, 0);
      // random sweep with occasional resets
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
